// File: rtl/arranque_pkg.sv
// Shared definitions for the parametrised soft-start ramp controller:
// state encoding, ramp defaults and small decode helpers.
package arranque_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_FULL      = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_RAMP_UP   = ST_RAMP_UP,
        S_FULL      = ST_FULL,
        S_RAMP_DOWN = ST_RAMP_DOWN
    } estado_t;

    localparam int DEF_N_STEPS    = 3;
    localparam int DEF_DWELL_UP   = 4;
    localparam int DEF_DWELL_DOWN = 2;
    localparam int DEF_CNT_W      = 8;

    function automatic logic es_rampa(input estado_t s);
        return (s == S_RAMP_UP) || (s == S_RAMP_DOWN);
    endfunction

endpackage

// File: rtl/arranque_rampa_param_temporizador_paso.sv
// Dwell downcounter: loads a reload value, decrements on tick, and stops at zero.
module temporizador_paso #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             cero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load wins over tick; a zero count holds so the counter never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cero = (cnt_q == '0);

endmodule

// File: rtl/arranque_rampa_param.sv
// Soft-start ramp controller: steps a speed level up/down through N_STEPS levels
// with programmable dwell, plus a direct-to-full fast start.
module arranque_rampa_param
    import arranque_pkg::*;
#(
    parameter int N_STEPS    = DEF_N_STEPS,
    parameter int DWELL_UP   = DEF_DWELL_UP,
    parameter int DWELL_DOWN = DEF_DWELL_DOWN,
    parameter int CNT_W      = DEF_CNT_W,
    localparam int LVL_W     = $clog2(N_STEPS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Rapido,
    input  logic               Lento,
    output logic [N_STEPS-1:0] out_nivel,
    output logic [LVL_W-1:0]   nivel,
    output logic               out_plena,
    output logic               out_rampa
);

    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(N_STEPS);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [CNT_W-1:0] RELOAD_UP = CNT_W'(DWELL_UP - 1);
    localparam logic [CNT_W-1:0] RELOAD_DN = CNT_W'(DWELL_DOWN - 1);

    estado_t            state_q;
    estado_t            state_d;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic [LVL_W-1:0]   level_inc;
    logic [LVL_W-1:0]   level_dec;

    logic [N_STEPS-1:0] out_nivel_q;
    logic [N_STEPS-1:0] out_nivel_d;
    logic               out_plena_q;
    logic               out_rampa_q;

    logic               run;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_tick;
    logic               cnt_cero;

    assign run = Rapido | Lento;

    // Saturating neighbours of the current level
    assign level_inc = (level_q == LVL_MAX) ? LVL_MAX : level_q + LVL_ONE;
    assign level_dec = (level_q == '0)      ? '0      : level_q - LVL_ONE;

    temporizador_paso #(
        .CNT_W (CNT_W)
    ) u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tick     (cnt_tick),
        .cero     (cnt_cero)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_tick     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Rapido) begin
                    state_d  = S_FULL;
                    level_d  = LVL_MAX;
                    cnt_load = 1'b1;
                end else if (Lento) begin
                    level_d      = LVL_ONE;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_UP;
                    state_d      = (N_STEPS == 1) ? S_FULL : S_RAMP_UP;
                end
            end

            S_RAMP_UP: begin
                if (Rapido) begin
                    state_d  = S_FULL;
                    level_d  = LVL_MAX;
                    cnt_load = 1'b1;
                end else if (!run) begin
                    state_d      = S_RAMP_DOWN;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_DN;
                end else if (cnt_cero) begin
                    level_d      = level_inc;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_UP;
                    if (level_inc == LVL_MAX) begin
                        state_d = S_FULL;
                    end
                end else begin
                    cnt_tick = 1'b1;
                end
            end

            S_FULL: begin
                if (!run) begin
                    state_d      = S_RAMP_DOWN;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_DN;
                end
            end

            S_RAMP_DOWN: begin
                if (Rapido) begin
                    state_d  = S_FULL;
                    level_d  = LVL_MAX;
                    cnt_load = 1'b1;
                end else if (Lento) begin
                    // Re-acceleration resumes from whatever level we reached
                    state_d      = S_RAMP_UP;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_UP;
                end else if (cnt_cero) begin
                    level_d      = level_dec;
                    cnt_load     = 1'b1;
                    cnt_load_val = RELOAD_DN;
                    if (level_dec == '0) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_tick = 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                level_d  = '0;
                cnt_load = 1'b1;
            end
        endcase
    end

    for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_onehot
        assign out_nivel_d[gi] = (level_d == LVL_W'(gi + 1));
    end

    // Outputs are decoded from next-state values so they land in flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            out_nivel_q <= '0;
            out_plena_q <= 1'b0;
            out_rampa_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            out_nivel_q <= out_nivel_d;
            out_plena_q <= (level_d == LVL_MAX);
            out_rampa_q <= es_rampa(state_d);
        end
    end

    assign out_nivel = out_nivel_q;
    assign nivel     = level_q;
    assign out_plena = out_plena_q;
    assign out_rampa = out_rampa_q;

endmodule

// File: tb/tb_arranque_rampa_param.sv
// Self-checking bench for arranque_rampa_param: directed scenarios with literal
// expectations, then randomized operator inputs against a behavioural model.
module tb_arranque_rampa_param;

    localparam int N  = 3;
    localparam int DU = 4;
    localparam int DD = 2;
    localparam int LW = $clog2(N + 1);

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_TOP  = 2;
    localparam int M_DOWN = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Rapido = 1'b0;
    logic          Lento = 1'b0;
    logic [N-1:0]  out_nivel;
    logic [LW-1:0] nivel;
    logic          out_plena;
    logic          out_rampa;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    arranque_rampa_param #(
        .N_STEPS    (N),
        .DWELL_UP   (DU),
        .DWELL_DOWN (DD),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Rapido    (Rapido),
        .Lento     (Lento),
        .out_nivel (out_nivel),
        .nivel     (nivel),
        .out_plena (out_plena),
        .out_rampa (out_rampa)
    );

    always #5 clk = ~clk;

    // Model: mode, level, and cycles already spent at the current level
    typedef struct packed {
        int mode;
        int lvl;
        int age;
    } mdl_t;

    mdl_t m = '{mode: M_OFF, lvl: 0, age: 0};

    function automatic mdl_t step(input mdl_t s, input logic r, input logic l);
        mdl_t n;
        n = s;
        if (r) begin
            n.mode = M_TOP;
            n.lvl  = N;
            n.age  = 0;
        end else if (!l) begin
            if (s.mode == M_UP || s.mode == M_TOP) begin
                n.mode = M_DOWN;
                n.age  = 0;
            end else if (s.mode == M_DOWN) begin
                if (s.age == DD - 1) begin
                    n.lvl = (s.lvl > 0) ? s.lvl - 1 : 0;
                    n.age = 0;
                    if (n.lvl == 0) n.mode = M_OFF;
                end else begin
                    n.age = s.age + 1;
                end
            end
        end else begin
            if (s.mode == M_OFF) begin
                n.lvl  = 1;
                n.age  = 0;
                n.mode = (N == 1) ? M_TOP : M_UP;
            end else if (s.mode == M_DOWN) begin
                n.mode = M_UP;
                n.age  = 0;
            end else if (s.mode == M_UP) begin
                if (s.age == DU - 1) begin
                    n.lvl = (s.lvl < N) ? s.lvl + 1 : N;
                    n.age = 0;
                    if (n.lvl == N) n.mode = M_TOP;
                end else begin
                    n.age = s.age + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{mode: M_OFF, lvl: 0, age: 0};
        else        m <= step(m, Rapido, Lento);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_nivel", int'(nivel), m.lvl);
            chk("model_onehot", int'(out_nivel), (m.lvl == 0) ? 0 : (1 << (m.lvl - 1)));
            chk("model_plena", int'(out_plena), (m.lvl == N) ? 1 : 0);
            chk("model_rampa", int'(out_rampa), (m.mode == M_UP || m.mode == M_DOWN) ? 1 : 0);
        end
    end

    task automatic drive(input logic r, input logic l);
        @(negedge clk);
        Rapido = r;
        Lento  = l;
    endtask

    initial begin
        int up_lvl[10];
        int up_oh[10];
        int dn_lvl[8];
        int dn_rmp[8];
        int re_lvl[5];
        int re_rmp[5];
        int dn_off;
        logic r_cur;
        logic l_cur;

        up_lvl = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
        up_oh  = '{1, 1, 1, 1, 2, 2, 2, 2, 4, 4};
        dn_lvl = '{3, 3, 2, 2, 1, 1, 0, 0};
        dn_rmp = '{1, 1, 1, 1, 1, 1, 0, 0};
        re_lvl = '{2, 2, 2, 2, 3};
        re_rmp = '{1, 1, 1, 1, 0};

        // Reset held, then released away from a clock edge
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_nivel", int'(nivel), 0);
        chk("rst_onehot", int'(out_nivel), 0);
        chk("rst_plena", int'(out_plena), 0);
        chk("rst_rampa", int'(out_rampa), 0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Idle with no request
        repeat (10) begin
            @(posedge clk);
            #1 chk("idle_nivel", int'(nivel), 0);
            chk("idle_rampa", int'(out_rampa), 0);
        end

        // Lento ramp-up 1 -> 2 -> 3
        drive(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 chk("up_nivel", int'(nivel), up_lvl[k]);
            chk("up_onehot", int'(out_nivel), up_oh[k]);
            chk("up_plena", int'(out_plena), (k >= 8) ? 1 : 0);
            chk("up_rampa", int'(out_rampa), (k >= 8) ? 0 : 1);
        end

        // Ramp-down from full to idle
        drive(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 chk("down_nivel", int'(nivel), dn_lvl[k]);
            chk("down_rampa", int'(out_rampa), dn_rmp[k]);
        end

        // Rapido pulse in idle goes straight to full, then Lento holds it
        drive(1'b1, 1'b0);
        @(posedge clk);
        #1 chk("fast_nivel", int'(nivel), 3);
        chk("fast_plena", int'(out_plena), 1);
        chk("fast_rampa", int'(out_rampa), 0);
        drive(1'b0, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1 chk("hold_nivel", int'(nivel), 3);
            chk("hold_rampa", int'(out_rampa), 0);
        end

        // Re-acceleration with Lento from level 2 during ramp-down
        drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("redn_nivel", int'(nivel), 2);
        drive(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 chk("reup_nivel", int'(nivel), re_lvl[k]);
            chk("reup_rampa", int'(out_rampa), re_rmp[k]);
            chk("reup_plena", int'(out_plena), (k == 4) ? 1 : 0);
        end

        // Same, but both requests high: one edge to full
        drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("redn2_nivel", int'(nivel), 2);
        drive(1'b1, 1'b1);
        @(posedge clk);
        #1 chk("both_nivel", int'(nivel), 3);
        chk("both_rampa", int'(out_rampa), 0);
        drive(1'b0, 1'b0);
        repeat (8) @(posedge clk);

        // Asynchronous reset mid-cycle at level 2 in ramp-up
        drive(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_nivel", int'(nivel), 2);
        chk("pre_rst_rampa", int'(out_rampa), 1);
        #2 reset = 1'b0;
        #1 chk("arst_nivel", int'(nivel), 0);
        chk("arst_onehot", int'(out_nivel), 0);
        chk("arst_plena", int'(out_plena), 0);
        chk("arst_rampa", int'(out_rampa), 0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("restart_nivel", int'(nivel), 1);
        chk("restart_rampa", int'(out_rampa), 1);

        // Randomized operator behaviour with occasional async reset pulses
        r_cur = 1'b0;
        l_cur = 1'b1;
        dn_off = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                r_cur = ($urandom_range(0, 3) == 0);
                l_cur = ($urandom_range(0, 1) == 1);
            end
            Rapido = r_cur;
            Lento  = l_cur;
            if ($urandom_range(0, 249) == 0) begin
                #1 reset = 1'b0;
                #1 chk("rnd_arst_nivel", int'(nivel), 0);
                dn_off++;
                #1 reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
